hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline and the hazard controller: ID/EXE hazard terms,
// MDU handshake, stall/flush controls and performance counters.
interface hazard_ctrl_if;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        uses_rs_id;
  logic        uses_rt_id;
  logic [4:0]  rd_exe;
  logic        RegWrite_exe;
  logic [1:0]  MemRead_exe;
  logic        branch_taken_id;
  logic        mdu_start_exe;
  logic        mdu_done;

  logic        pc_stall;
  logic        ifid_stall;
  logic        idexe_stall;
  logic        ifid_flush;
  logic        idexe_flush;
  logic        exemem_flush;
  logic [1:0]  hz_state;
  logic        mdu_timeout;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output rs_id, rt_id, uses_rs_id, uses_rt_id, rd_exe, RegWrite_exe,
           MemRead_exe, branch_taken_id, mdu_start_exe, mdu_done,
    input  pc_stall, ifid_stall, idexe_stall, ifid_flush, idexe_flush,
           exemem_flush, hz_state, mdu_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_id, rt_id, uses_rs_id, uses_rt_id, rd_exe, RegWrite_exe,
           MemRead_exe, branch_taken_id, mdu_start_exe, mdu_done,
    output pc_stall, ifid_stall, idexe_stall, ifid_flush, idexe_flush,
           exemem_flush, hz_state, mdu_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: MDU wait stall with timeout, load-use bubble,
// taken-branch flush, and saturating stall/flush performance counters.
module hazard_ctrl (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 6;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mdu_stall_c;
  logic load_use_c;
  logic rs_hit_c;
  logic rt_hit_c;
  logic pc_stall_c;
  logic ifid_flush_c;
  logic idexe_flush_c;
  logic mdu_hold_c;

  // Hazard detection; priority is MDU wait, then load-use, then branch flush
  always_comb begin
    mdu_stall_c = 1'b0;
    if (state_q == ST_IDLE) begin
      mdu_stall_c = hz.mdu_start_exe & ~hz.mdu_done;
    end else if (state_q == ST_BUSY) begin
      mdu_stall_c = ~hz.mdu_done;
    end

    rs_hit_c   = hz.uses_rs_id & (hz.rs_id == hz.rd_exe);
    rt_hit_c   = hz.uses_rt_id & (hz.rt_id == hz.rd_exe);
    load_use_c = ~mdu_stall_c & hz.RegWrite_exe & (hz.MemRead_exe != 2'b00)
               & (hz.rd_exe != 5'd0) & (rs_hit_c | rt_hit_c);

    mdu_hold_c    = ~rst & mdu_stall_c;
    pc_stall_c    = ~rst & (mdu_stall_c | load_use_c);
    idexe_flush_c = ~rst & load_use_c;
    ifid_flush_c  = ~rst & hz.branch_taken_id & ~mdu_stall_c & ~load_use_c;
  end

  assign hz.pc_stall     = pc_stall_c;
  assign hz.ifid_stall   = pc_stall_c;
  assign hz.idexe_stall  = mdu_hold_c;
  assign hz.exemem_flush = mdu_hold_c;
  assign hz.idexe_flush  = idexe_flush_c;
  assign hz.ifid_flush   = ifid_flush_c;
  assign hz.hz_state     = state_q;
  assign hz.mdu_timeout  = tmo_q;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;

  // MDU wait FSM; a start while busy is ignored
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (hz.mdu_start_exe & ~hz.mdu_done) begin
          state_d = ST_BUSY;
          wait_d  = '0;
        end
      end
      ST_BUSY: begin
        if (hz.mdu_done) begin
          state_d = ST_IDLE;
        end else if (wait_q == WAIT_MAX) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ifid_flush_c && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      tmo_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit m_busy;
  int m_wait;
  bit m_tmo;
  int m_scnt;
  int m_fcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    hif.rs_id           = 5'd0;
    hif.rt_id           = 5'd0;
    hif.uses_rs_id      = 1'b0;
    hif.uses_rt_id      = 1'b0;
    hif.rd_exe          = 5'd0;
    hif.RegWrite_exe    = 1'b0;
    hif.MemRead_exe     = 2'b00;
    hif.branch_taken_id = 1'b0;
    hif.mdu_start_exe   = 1'b0;
    hif.mdu_done        = 1'b0;
  endtask

  task automatic set_load_use(input int rd, input int rs, input bit urs);
    hif.RegWrite_exe = 1'b1;
    hif.MemRead_exe  = 2'b01;
    hif.rd_exe       = 5'(rd);
    hif.rs_id        = 5'(rs);
    hif.uses_rs_id   = urs;
  endtask

  // One cycle: check outputs mid-cycle against the model, then advance the model
  task automatic step();
    bit ms, lu, pcs, ifl;
    @(negedge clk);
    ms = 1'b0;
    lu = 1'b0;
    if (!rst) begin
      ms = m_busy ? !hif.mdu_done : (hif.mdu_start_exe && !hif.mdu_done);
      lu = !ms && hif.RegWrite_exe && (hif.MemRead_exe != 0) && (hif.rd_exe != 0) &&
           ((hif.uses_rs_id && hif.rs_id == hif.rd_exe) ||
            (hif.uses_rt_id && hif.rt_id == hif.rd_exe));
    end
    pcs = ms || lu;
    ifl = !rst && hif.branch_taken_id && !ms && !lu;
    check("pc_stall",     32'(hif.pc_stall),     32'(pcs));
    check("ifid_stall",   32'(hif.ifid_stall),   32'(pcs));
    check("idexe_stall",  32'(hif.idexe_stall),  32'(ms));
    check("exemem_flush", 32'(hif.exemem_flush), 32'(ms));
    check("idexe_flush",  32'(hif.idexe_flush),  32'(lu));
    check("ifid_flush",   32'(hif.ifid_flush),   32'(ifl));
    check("hz_state",     32'(hif.hz_state),     32'(m_busy));
    check("mdu_timeout",  32'(hif.mdu_timeout),  32'(m_tmo));
    check("stall_cnt",    32'(hif.stall_cnt),    32'(m_scnt));
    check("flush_cnt",    32'(hif.flush_cnt),    32'(m_fcnt));
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_wait = 0; m_tmo = 1'b0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (pcs && m_scnt < 65535) m_scnt++;
      if (ifl && m_fcnt < 65535) m_fcnt++;
      if (!m_busy) begin
        if (hif.mdu_start_exe && !hif.mdu_done) begin
          m_busy = 1'b1;
          m_wait = 0;
        end
      end else if (hif.mdu_done) begin
        m_busy = 1'b0;
      end else if (m_wait == 63) begin
        m_busy = 1'b0;
        m_tmo  = 1'b1;
      end else begin
        m_wait++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_busy = 1'b0; m_wait = 0; m_tmo = 1'b0; m_scnt = 0; m_fcnt = 0;
    step();
    rst = 1'b0;
    check("rst_hz_state", 32'(hif.hz_state), 32'd0);
    check("rst_stall_cnt", 32'(hif.stall_cnt), 32'd0);
    check("rst_tmo", 32'(hif.mdu_timeout), 32'd0);

    // Single-cycle load-use bubble
    do_reset();
    set_load_use(5, 5, 1'b1);
    #1;
    check("lu_pc_stall", 32'(hif.pc_stall), 32'd1);
    check("lu_idexe_flush", 32'(hif.idexe_flush), 32'd1);
    check("lu_idexe_stall", 32'(hif.idexe_stall), 32'd0);
    step();
    clear_inputs();
    #1;
    check("lu_gone", 32'(hif.pc_stall), 32'd0);
    step();
    check("lu_stall_cnt", 32'(hif.stall_cnt), 32'd1);

    // r0 destination and unused source are not hazards
    set_load_use(0, 0, 1'b1);
    #1;
    check("r0_pc_stall", 32'(hif.pc_stall), 32'd0);
    step();
    set_load_use(5, 5, 1'b0);
    #1;
    check("nouse_pc_stall", 32'(hif.pc_stall), 32'd0);
    step();
    clear_inputs();

    // Branch held off by load-use, then flushes
    do_reset();
    set_load_use(7, 7, 1'b1);
    hif.branch_taken_id = 1'b1;
    #1;
    check("br_lu_ifid_flush", 32'(hif.ifid_flush), 32'd0);
    step();
    hif.RegWrite_exe = 1'b0;
    #1;
    check("br_ifid_flush", 32'(hif.ifid_flush), 32'd1);
    step();
    clear_inputs();
    check("br_flush_cnt", 32'(hif.flush_cnt), 32'd1);

    // MDU op: start at cycle 0, done at cycle 4
    do_reset();
    hif.mdu_start_exe = 1'b1;
    #1;
    check("mdu_c0_stall", 32'(hif.pc_stall), 32'd1);
    check("mdu_c0_exemem", 32'(hif.exemem_flush), 32'd1);
    step();
    hif.mdu_start_exe = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("mdu_busy_state", 32'(hif.hz_state), 32'd1);
      check("mdu_busy_stall", 32'(hif.pc_stall), 32'd1);
      step();
    end
    hif.mdu_done = 1'b1;
    #1;
    check("mdu_done_stall", 32'(hif.pc_stall), 32'd0);
    check("mdu_done_state", 32'(hif.hz_state), 32'd1);
    step();
    hif.mdu_done = 1'b0;
    check("mdu_after_state", 32'(hif.hz_state), 32'd0);
    check("mdu_stall_cnt", 32'(hif.stall_cnt), 32'd4);

    // Single-cycle MDU op never stalls
    hif.mdu_start_exe = 1'b1;
    hif.mdu_done      = 1'b1;
    #1;
    check("mdu_1c_stall", 32'(hif.pc_stall), 32'd0);
    step();
    clear_inputs();
    check("mdu_1c_state", 32'(hif.hz_state), 32'd0);

    // Timeout after the 64th BUSY cycle
    do_reset();
    hif.mdu_start_exe = 1'b1;
    step();
    hif.mdu_start_exe = 1'b0;
    repeat (63) step();
    check("tmo_63_state", 32'(hif.hz_state), 32'd1);
    check("tmo_63_flag", 32'(hif.mdu_timeout), 32'd0);
    step();
    check("tmo_state", 32'(hif.hz_state), 32'd0);
    check("tmo_flag", 32'(hif.mdu_timeout), 32'd1);
    check("tmo_stall_cnt", 32'(hif.stall_cnt), 32'd65);
    repeat (5) step();
    check("tmo_sticky", 32'(hif.mdu_timeout), 32'd1);
    do_reset();
    check("tmo_cleared", 32'(hif.mdu_timeout), 32'd0);

    // Reset mid-BUSY aborts without timeout, outputs forced low during reset
    hif.mdu_start_exe = 1'b1;
    step();
    hif.mdu_start_exe = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    set_load_use(3, 3, 1'b1);
    hif.branch_taken_id = 1'b1;
    #1;
    check("rst_force_pc", 32'(hif.pc_stall), 32'd0);
    check("rst_force_ifl", 32'(hif.ifid_flush), 32'd0);
    step();
    rst = 1'b0;
    clear_inputs();
    check("rstb_state", 32'(hif.hz_state), 32'd0);
    check("rstb_scnt", 32'(hif.stall_cnt), 32'd0);
    check("rstb_tmo", 32'(hif.mdu_timeout), 32'd0);

    // Stall counter saturation under a held load-use
    do_reset();
    set_load_use(9, 9, 1'b1);
    repeat (65540) step();
    check("sat_stall_cnt", 32'(hif.stall_cnt), 32'hFFFF);
    clear_inputs();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      hif.rs_id           = 5'($urandom_range(0, 3));
      hif.rt_id           = 5'($urandom_range(0, 3));
      hif.rd_exe          = 5'($urandom_range(0, 3));
      hif.uses_rs_id      = 1'($urandom_range(0, 1));
      hif.uses_rt_id      = 1'($urandom_range(0, 1));
      hif.RegWrite_exe    = 1'($urandom_range(0, 1));
      hif.MemRead_exe     = 2'($urandom_range(0, 3));
      hif.branch_taken_id = 1'($urandom_range(0, 1));
      hif.mdu_start_exe   = ($urandom_range(0, 7) == 0);
      hif.mdu_done        = ($urandom_range(0, 5) == 0);
      rst                 = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
